// File: rtl/genie_pipe_chain.sv
// Cascade of DEPTH valid/ready register stages, each either a skid stage (SKID=1) or a forward-registered stage (SKID=0).
// Optional stall-cycle counter output o_stall_cnt is enabled by defining GENIE_PIPE_CHAIN_STALL_CNT_EN.
module genie_pipe_chain #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 2,
  parameter int SKID  = 1,
  localparam int CW   = $clog2(2*DEPTH+2)
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_valid,
  output logic             o_ready,
  output logic [WIDTH-1:0] o_data,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [CW-1:0]    o_count
`ifdef GENIE_PIPE_CHAIN_STALL_CNT_EN
  ,
  output logic [31:0]      o_stall_cnt
`endif
);

  if (DEPTH == 0) begin : g_wire
    assign o_data  = i_data;
    assign o_valid = i_valid;
    assign o_ready = i_ready;
    assign o_count = '0;
  end else begin : g_chain
    // Index g is the interface feeding stage g; index DEPTH faces the downstream port.
    logic [WIDTH-1:0] stage_data [0:DEPTH];
    logic [DEPTH:0]   stage_valid;
    logic [DEPTH:0]   stage_ready;
    logic             in_fire;
    logic             out_fire;

    assign stage_data[0]      = i_data;
    assign stage_valid[0]     = i_valid;
    assign stage_ready[DEPTH] = i_ready;
    assign o_ready            = stage_ready[0];
    assign o_data             = stage_data[DEPTH];
    assign o_valid            = stage_valid[DEPTH];

    for (genvar g = 0; g < DEPTH; g++) begin : g_stage
      if (SKID != 0) begin : g_skid
        logic             ov;
        logic             sv;
        logic [WIDTH-1:0] od;
        logic [WIDTH-1:0] sd;
        logic             in_xfer;

        assign stage_ready[g]     = !sv;
        assign in_xfer            = stage_valid[g] && !sv;
        assign stage_valid[g+1]   = ov;
        assign stage_data[g+1]    = od;

        // A held skid word always refills the output register before any newer word is taken.
        always_ff @(posedge i_clk) begin
          if (i_reset) begin
            ov <= 1'b0;
            sv <= 1'b0;
          end else if (!ov || stage_ready[g+1]) begin
            if (sv) begin
              ov <= 1'b1;
              od <= sd;
              sv <= 1'b0;
            end else begin
              ov <= in_xfer;
              if (in_xfer) od <= stage_data[g];
            end
          end else if (in_xfer) begin
            sv <= 1'b1;
            sd <= stage_data[g];
          end
        end
      end else begin : g_fwd
        logic             ov;
        logic [WIDTH-1:0] od;

        // Ready is flattened over the downstream occupancy bits so no signal depends on itself.
        assign stage_ready[g]   = i_ready || !(&stage_valid[DEPTH:g+1]);
        assign stage_valid[g+1] = ov;
        assign stage_data[g+1]  = od;

        always_ff @(posedge i_clk) begin
          if (i_reset) begin
            ov <= 1'b0;
          end else if (stage_ready[g]) begin
            ov <= stage_valid[g];
            if (stage_valid[g]) od <= stage_data[g];
          end
        end
      end
    end

    assign in_fire  = i_valid && stage_ready[0];
    assign out_fire = stage_valid[DEPTH] && i_ready;

    always_ff @(posedge i_clk) begin
      if (i_reset) begin
        o_count <= '0;
      end else if (in_fire && !out_fire) begin
        o_count <= o_count + CW'(1);
      end else if (!in_fire && out_fire) begin
        o_count <= o_count - CW'(1);
      end
    end
  end

`ifdef GENIE_PIPE_CHAIN_STALL_CNT_EN
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_stall_cnt <= '0;
    end else if (o_valid && !i_ready && (o_stall_cnt != 32'hFFFF_FFFF)) begin
      o_stall_cnt <= o_stall_cnt + 32'd1;
    end
  end
`endif

endmodule
